fir_filter_mac: RTL and testbench

FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

---
 rtl/fir_filter_mac.sv | 123 ++++++++++++
 tb/tb_fir_filter_mac.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// rtl/fir_filter_mac.sv - single-MAC time-multiplexed FIR filter
// One product per cycle over a circular delay line; one output per TAPS+2 cycles.
module fir_filter_mac #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int TAPS      = 128,
  parameter int OUT_SHIFT = 16,
  parameter int SAT       = 0,
  localparam int AW       = $clog2(TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid
);
  localparam int P_W = DATA_W + COEF_W;
  localparam int KW  = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC} state_t;
  state_t state_q, state_d;

  logic signed [DATA_W-1:0] delay [TAPS];
  logic signed [COEF_W-1:0] coef  [TAPS];

  logic [AW-1:0]            clr_idx, wr_ptr, rd_ptr, k_idx;
  logic [KW-1:0]            k_q;
  logic                     accept, mac_last, coef_ok, prod_vld;
  logic                     ovf_hi, ovf_lo;
  logic signed [P_W-1:0]    prod_w, prod_r;
  logic signed [ACC_W-1:0]  acc, acc_next, shifted;
  logic signed [DATA_W-1:0] out_next;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign mac_last = (state_q == S_MAC) && (k_q == KW'(TAPS));
  assign coef_ok  = ({1'b0, coef_addr} < KW'(TAPS));
  // k reaches TAPS on the drain cycle; keep the read index in range then
  assign k_idx    = mac_last ? '0 : k_q[AW-1:0];
  assign prod_w   = P_W'(coef[k_idx]) * P_W'(delay[rd_ptr]);
  assign acc_next = acc + (prod_vld ? ACC_W'(prod_r) : '0);

  always_comb begin
    shifted  = acc_next >>> OUT_SHIFT;
    ovf_hi   = (shifted > SAT_MAX);
    ovf_lo   = (shifted < SAT_MIN);
    out_next = shifted[DATA_W-1:0];
    if (SAT != 0 && ovf_hi)      out_next = SAT_MAX[DATA_W-1:0];
    else if (SAT != 0 && ovf_lo) out_next = SAT_MIN[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_idx == LAST) state_d = S_IDLE;
      S_IDLE:  if (accept)          state_d = S_MAC;
      S_MAC:   if (mac_last)        state_d = S_IDLE;
      default:                      state_d = S_CLEAR;
    endcase
  end

  // Coefficients are deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (rst_n && coef_we && in_ready && coef_ok) coef[coef_addr] <= coef_data;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) delay[clr_idx] <= '0;
    else if (accept)        delay[wr_ptr]  <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_idx   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      k_q       <= '0;
      acc       <= '0;
      prod_r    <= '0;
      prod_vld  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      prod_r    <= prod_w;
      prod_vld  <= (state_q == S_MAC) && !mac_last;
      case (state_q)
        S_CLEAR: clr_idx <= (clr_idx == LAST) ? '0 : clr_idx + AW'(1);
        S_IDLE: begin
          if (accept) begin
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            rd_ptr <= wr_ptr;
            k_q    <= '0;
            acc    <= '0;
          end
        end
        S_MAC: begin
          k_q    <= k_q + KW'(1);
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - AW'(1);
          acc    <= acc_next;
          // final registered product is folded in on the same edge as the output
          if (mac_last) begin
            out_data  <= out_next;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mac.sv
// tb/tb_fir_filter_mac.sv - randomized self-checking bench for fir_filter_mac
// Three DUTs share stimulus: wrap/no-shift, saturate/no-shift, saturate/shift-1.
module tb_fir_filter_mac;
  localparam int TAPS = 8;
  localparam int DW   = 8;
  localparam int LAT  = TAPS + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 ir [3];
  logic                 ov [3];
  logic signed [DW-1:0] od [3];

  int total = 0;
  int bad   = 0;
  int coef_m [TAPS];
  int hist [$];

  always #5 clk = ~clk;

  fir_filter_mac #(.DATA_W(DW), .COEF_W(DW), .TAPS(TAPS), .OUT_SHIFT(0), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(od[0]), .out_valid(ov[0]));
  fir_filter_mac #(.DATA_W(DW), .COEF_W(DW), .TAPS(TAPS), .OUT_SHIFT(0), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(od[1]), .out_valid(ov[1]));
  fir_filter_mac #(.DATA_W(DW), .COEF_W(DW), .TAPS(TAPS), .OUT_SHIFT(1), .SAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_data(od[2]), .out_valid(ov[2]));

  // y = sum_k c[k]*x[n-k], then >>> shift, then wrap or clamp to 8 bits
  function automatic logic signed [7:0] model_out(input int shift, input bit sat);
    longint acc = 0;
    for (int k = 0; k < hist.size(); k++) acc += longint'(coef_m[k]) * longint'(hist[k]);
    acc = acc >>> shift;
    if (sat) begin
      if (acc > 127) acc = 127;
      else if (acc < -128) acc = -128;
    end
    return 8'(acc);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_hist(input int x);
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    hist.delete();
  endtask

  task automatic write_coef(input int a, input int v);
    int n = 0;
    while (!ir[0] && n < 200) begin tick; n++; end
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = DW'(v);
    tick;
    coef_we = 1'b0;
    coef_m[a] = v;
  endtask

  task automatic send_sample(input int x, input bit wc, input int wa, input int wv,
                             output int lat, output logic [2:0][7:0] got,
                             output logic rdy_at_out, output logic ov_after);
    int n = 0;
    while (!ir[0] && n < 200) begin tick; n++; end
    in_valid = 1'b1; in_data = DW'(x);
    coef_we = wc; coef_addr = 3'(wa); coef_data = DW'(wv);
    tick;
    in_valid = 1'b0; coef_we = 1'b0;
    if (wc) coef_m[wa] = wv;
    push_hist(x);
    lat = 1;
    while (!ov[0] && lat < 4 * LAT) begin tick; lat++; end
    for (int i = 0; i < 3; i++) got[i] = od[i];
    rdy_at_out = ir[0];
    tick;
    ov_after = ov[0];
  endtask

  task automatic test_reset;
    int n = 0;
    rst_n = 1'b0; in_valid = 1'b0; coef_we = 1'b0;
    in_data = '0; coef_addr = '0; coef_data = '0;
    tick; tick; tick;
    for (int i = 0; i < 3; i++) begin
      total++; if (ir[i] !== 1'b0) begin bad++; $display("FAIL reset_in_ready dut%0d got=%b want=0", i, ir[i]); end
      total++; if (ov[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%b want=0", i, ov[i]); end
      total++; if (od[i] !== 8'sd0) begin bad++; $display("FAIL reset_out_data dut%0d got=%0d want=0", i, od[i]); end
    end
    rst_n = 1'b1;
    hist.delete();
    while (!ir[0] && n < 4 * TAPS) begin tick; n++; end
    total++; if (n !== TAPS) begin bad++; $display("FAIL clear_cycles got=%0d want=%0d", n, TAPS); end
  endtask

  task automatic test_impulse;
    int lat; logic [2:0][7:0] got; logic rdy, ova; logic signed [7:0] e;
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    for (int n = 0; n <= TAPS; n++) begin
      send_sample(n == 0 ? 1 : 0, 1'b0, 0, 0, lat, got, rdy, ova);
      total++; if (lat !== LAT) begin bad++; $display("FAIL impulse_latency n=%0d got=%0d want=%0d", n, lat, LAT); end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL impulse_ready_at_out n=%0d got=%b want=1", n, rdy); end
      total++; if (ova !== 1'b0) begin bad++; $display("FAIL impulse_pulse_width n=%0d got=%b want=0", n, ova); end
      total++; if (int'($signed(got[0])) !== (n < TAPS ? n + 1 : 0)) begin
        bad++; $display("FAIL impulse_const n=%0d got=%0d want=%0d", n, $signed(got[0]), (n < TAPS ? n + 1 : 0));
      end
      for (int i = 0; i < 3; i++) begin
        e = model_out(i == 2 ? 1 : 0, i >= 1);
        total++; if (got[i] !== e) begin bad++; $display("FAIL impulse_model dut%0d n=%0d got=%0d want=%0d", i, n, $signed(got[i]), e); end
      end
    end
  endtask

  task automatic test_step;
    int lat; logic [2:0][7:0] got; logic rdy, ova; int want;
    for (int k = 0; k < TAPS; k++) write_coef(k, 1);
    for (int n = 0; n < TAPS + 3; n++) begin
      send_sample(5, 1'b0, 0, 0, lat, got, rdy, ova);
      want = 5 * ((n + 1 < TAPS) ? n + 1 : TAPS);
      total++; if (int'($signed(got[0])) !== want) begin bad++; $display("FAIL step_out n=%0d got=%0d want=%0d", n, $signed(got[0]), want); end
      total++; if (od[0] !== $signed(got[0])) begin bad++; $display("FAIL step_hold n=%0d got=%0d want=%0d", n, od[0], $signed(got[0])); end
    end
  endtask

  task automatic test_sign_shift;
    int lat; logic [2:0][7:0] got; logic rdy, ova; logic signed [7:0] e;
    apply_reset();
    for (int n = 0; n < TAPS; n++) begin
      send_sample(-1, 1'b0, 0, 0, lat, got, rdy, ova);
      total++; if (int'($signed(got[0])) !== -(n + 1)) begin bad++; $display("FAIL sign_out n=%0d got=%0d want=%0d", n, $signed(got[0]), -(n + 1)); end
      if (n == 0) begin
        total++; if (int'($signed(got[2])) !== -1) begin bad++; $display("FAIL shift_first got=%0d want=-1", $signed(got[2])); end
      end
      e = model_out(1, 1'b1);
      total++; if (got[2] !== e) begin bad++; $display("FAIL shift_model n=%0d got=%0d want=%0d", n, $signed(got[2]), e); end
    end
  endtask

  task automatic test_saturation;
    int lat; logic [2:0][7:0] got; logic rdy, ova; logic [7:0] wrap_want; int m;
    apply_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 127);
    for (int n = 0; n <= TAPS; n++) begin
      send_sample(127, 1'b0, 0, 0, lat, got, rdy, ova);
      m = (n + 1 < TAPS) ? n + 1 : TAPS;
      wrap_want = 8'(127 * 127 * m);
      total++; if (got[0] !== wrap_want) begin bad++; $display("FAIL sat0_wrap n=%0d got=%0d want=%0d", n, got[0], wrap_want); end
      total++; if (int'($signed(got[1])) !== 127) begin bad++; $display("FAIL sat1_clamp n=%0d got=%0d want=127", n, $signed(got[1])); end
      total++; if (int'($signed(got[2])) !== 127) begin bad++; $display("FAIL sat1_shift_clamp n=%0d got=%0d want=127", n, $signed(got[2])); end
    end
  endtask

  task automatic test_random;
    int lat; logic [2:0][7:0] got; logic rdy, ova; logic signed [7:0] e; bit wc;
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
    for (int n = 0; n < 24; n++) begin
      wc = (n % 4 == 1);
      send_sample(int'($urandom_range(0, 255)) - 128, wc, int'($urandom_range(0, TAPS - 1)),
                  int'($urandom_range(0, 255)) - 128, lat, got, rdy, ova);
      total++; if (lat !== LAT) begin bad++; $display("FAIL random_latency n=%0d got=%0d want=%0d", n, lat, LAT); end
      for (int i = 0; i < 3; i++) begin
        e = model_out(i == 2 ? 1 : 0, i >= 1);
        total++; if (got[i] !== e) begin bad++; $display("FAIL random_model dut%0d n=%0d got=%0d want=%0d", i, n, $signed(got[i]), e); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0][7:0] q [$];
    logic [2:0][7:0] ex;
    int last_acc = -100;
    int n_acc = 0;
    apply_reset();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < TAPS + 5 * LAT; cyc++) begin
      in_data   = DW'($urandom_range(0, 255));
      coef_we   = (n_acc > 0 && cyc == last_acc + 3);
      coef_addr = 3'($urandom_range(0, TAPS - 1));
      coef_data = DW'($urandom_range(0, 255));
      if (ov[0]) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL b2b_unexpected_out cyc=%0d got=1 want=0", cyc); end
        else begin
          ex = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            total++; if (od[i] !== $signed(ex[i])) begin bad++; $display("FAIL b2b_out dut%0d cyc=%0d got=%0d want=%0d", i, cyc, od[i], $signed(ex[i])); end
          end
        end
      end
      if (ir[0]) begin
        if (n_acc == 0) begin
          total++; if (cyc !== TAPS) begin bad++; $display("FAIL b2b_first_accept got=%0d want=%0d", cyc, TAPS); end
        end else begin
          total++; if (cyc - last_acc !== LAT) begin bad++; $display("FAIL b2b_interval got=%0d want=%0d", cyc - last_acc, LAT); end
        end
        last_acc = cyc;
        n_acc++;
        push_hist(int'(in_data));
        for (int i = 0; i < 3; i++) ex[i] = model_out(i == 2 ? 1 : 0, i >= 1);
        q.push_back(ex);
      end
      tick;
    end
    in_valid = 1'b0; coef_we = 1'b0;
    for (int d = 0; d < 2 * LAT; d++) begin
      if (ov[0] && q.size() > 0) begin
        ex = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          total++; if (od[i] !== $signed(ex[i])) begin bad++; $display("FAIL b2b_drain dut%0d got=%0d want=%0d", i, od[i], $signed(ex[i])); end
        end
      end
      tick;
    end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL b2b_missing_outputs got=%0d want=0", q.size()); end
    total++; if (n_acc !== 5) begin bad++; $display("FAIL b2b_accept_count got=%0d want=5", n_acc); end
  endtask

  task automatic test_reset_mid_mac;
    int n = 0; int seen = 0;
    int lat; logic [2:0][7:0] got; logic rdy, ova;
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
    while (!ir[0] && n < 200) begin tick; n++; end
    in_valid = 1'b1; in_data = 8'sd1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    tick;
    total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL midmac_reset_ready got=%b want=0", ir[0]); end
    total++; if (od[0] !== 8'sd0) begin bad++; $display("FAIL midmac_reset_out_data got=%0d want=0", od[0]); end
    rst_n = 1'b1;
    hist.delete();
    for (int c = 0; c < 3 * TAPS; c++) begin
      if (ov[0] || ov[1] || ov[2]) seen++;
      tick;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midmac_spurious_out got=%0d want=0", seen); end
    for (int k = 0; k <= TAPS; k++) begin
      send_sample(k == 0 ? 1 : 0, 1'b0, 0, 0, lat, got, rdy, ova);
      total++; if (int'($signed(got[0])) !== (k < TAPS ? k + 1 : 0)) begin
        bad++; $display("FAIL midmac_impulse n=%0d got=%0d want=%0d", k, $signed(got[0]), (k < TAPS ? k + 1 : 0));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    test_reset();
    test_impulse();
    test_step();
    test_sign_shift();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid_mac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
